cpu_control_fsm: RTL and testbench

Multi-cycle sequencer for the 16-bit CPU datapath: drives the program counter, instruction register, register-bank write, flag register, ALU/BRAM bus mux, BRAM port-A address source and write enable. Decodes instruction class from the IR output and evaluates branch/jump conditions against the stored flags. Replaces the three-output fetch FSM. Adds memory-latency wait states, a run/halt gate and a retired-instruction counter.

---
 rtl/cpu_control_fsm.sv | 177 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetch/latch/execute with BRAM
// wait states, instruction-class decode, branch condition evaluation and a retire counter.
module cpu_control_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic [4:0]  flags,
    output logic        pc_enable,
    output logic        pc_load,
    output logic        pc_src,
    output logic        ir_enable,
    output logic        r_enable,
    output logic        link_sel,
    output logic        flags_enable,
    output logic        alu_bus_sel,
    output logic        mem_addr_sel,
    output logic        we_a,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_EXEC      = 3'd3,
        S_LOAD_WAIT = 3'd4,
        S_LOAD_WB   = 3'd5
    } state_t;

    // Last wait-counter value in each held state.
    localparam logic [1:0] FETCH_LAST = 2'(MEM_LAT - 1);
    localparam logic [1:0] LWAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_t     cur, nxt;
    logic [1:0] wcnt, wcnt_nxt;

    logic [3:0] op, sub, cc;
    logic       mem_grp, is_load, is_stor, is_jal, is_jcond, is_bcond, no_flags, cond_ok;
    logic       flag_c, flag_l, flag_f, flag_z, flag_n;
    logic       unused_raddr;

    assign op  = instr[15:12];
    assign cc  = instr[11:8];
    assign sub = instr[7:4];
    assign unused_raddr = ^instr[3:0];

    assign {flag_n, flag_z, flag_f, flag_l, flag_c} = flags;

    assign mem_grp  = (op == 4'b0100);
    assign is_load  = mem_grp && (sub == 4'b0000);
    assign is_stor  = mem_grp && (sub == 4'b0100);
    assign is_jal   = mem_grp && (sub == 4'b1000);
    assign is_jcond = mem_grp && (sub == 4'b1100);
    assign is_bcond = (op == 4'b1100);
    // MOVI, LUI and register MOV write a register without touching flags.
    assign no_flags = (op == 4'b1101) || (op == 4'b1111) ||
                      ((op == 4'b0000) && (sub == 4'b1101));

    always_comb begin
        cond_ok = 1'b0;
        case (cc)
            4'h0: cond_ok = flag_z;
            4'h1: cond_ok = !flag_z;
            4'h2: cond_ok = flag_c;
            4'h3: cond_ok = !flag_c;
            4'h4: cond_ok = flag_l;
            4'h5: cond_ok = !flag_l;
            4'h6: cond_ok = flag_n;
            4'h7: cond_ok = !flag_n;
            4'h8: cond_ok = flag_f;
            4'h9: cond_ok = !flag_f;
            4'hA: cond_ok = !flag_l && !flag_z;
            4'hB: cond_ok = flag_l || flag_z;
            4'hC: cond_ok = !flag_n && !flag_z;
            4'hD: cond_ok = flag_n || flag_z;
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur  <= S_IDLE;
            wcnt <= 2'd0;
        end else begin
            cur  <= nxt;
            wcnt <= wcnt_nxt;
        end
    end

    always_comb begin
        nxt          = S_IDLE;
        wcnt_nxt     = 2'd0;
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        pc_src       = 1'b0;
        ir_enable    = 1'b0;
        r_enable     = 1'b0;
        link_sel     = 1'b0;
        flags_enable = 1'b0;
        alu_bus_sel  = 1'b0;
        mem_addr_sel = 1'b0;
        we_a         = 1'b0;
        case (cur)
            S_IDLE: nxt = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (wcnt == FETCH_LAST) begin
                    nxt = S_LATCH;
                end else begin
                    nxt      = S_FETCH;
                    wcnt_nxt = wcnt + 2'd1;
                end
            end
            S_LATCH: begin
                ir_enable = 1'b1;
                nxt       = S_EXEC;
            end
            S_EXEC: begin
                nxt = run ? S_FETCH : S_IDLE;
                if (is_load) begin
                    mem_addr_sel = 1'b1;
                    nxt          = (MEM_LAT > 1) ? S_LOAD_WAIT : S_LOAD_WB;
                end else if (is_stor) begin
                    mem_addr_sel = 1'b1;
                    we_a         = 1'b1;
                    pc_enable    = 1'b1;
                end else if (is_jal) begin
                    r_enable = 1'b1;
                    link_sel = 1'b1;
                    pc_load  = 1'b1;
                    pc_src   = 1'b1;
                end else if (is_bcond || is_jcond) begin
                    // pc_src only matters on a taken branch; Jcond targets Raddr.
                    pc_load   = cond_ok;
                    pc_src    = cond_ok && is_jcond;
                    pc_enable = !cond_ok;
                end else begin
                    alu_bus_sel  = 1'b1;
                    r_enable     = 1'b1;
                    pc_enable    = 1'b1;
                    flags_enable = !no_flags;
                end
            end
            S_LOAD_WAIT: begin
                mem_addr_sel = 1'b1;
                if (wcnt == LWAIT_LAST) begin
                    nxt = S_LOAD_WB;
                end else begin
                    nxt      = S_LOAD_WAIT;
                    wcnt_nxt = wcnt + 2'd1;
                end
            end
            S_LOAD_WB: begin
                mem_addr_sel = 1'b1;
                r_enable     = 1'b1;
                pc_enable    = 1'b1;
                nxt          = run ? S_FETCH : S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Each instruction moves the PC exactly once, so that cycle marks retirement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired <= 16'd0;
        else if (pc_enable || pc_load)
            retired <= retired + 16'd1;
    end

    assign state = cur;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: MEM_LAT=1 and MEM_LAT=2 instances share stimulus and are
// checked every cycle against an instruction-position model, plus literal expectations.
module tb_cpu_control_fsm;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [4:0]  flags = 5'd0;

    // ctl bit order: pc_enable pc_load pc_src ir_enable r_enable link_sel flags_enable alu_bus_sel mem_addr_sel we_a
    wire [9:0]  c0, c1;
    wire [2:0]  st0, st1;
    wire [15:0] ret0, ret1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_control_fsm #(.MEM_LAT(1)) u0 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .flags(flags),
        .pc_enable(c0[9]), .pc_load(c0[8]), .pc_src(c0[7]), .ir_enable(c0[6]),
        .r_enable(c0[5]), .link_sel(c0[4]), .flags_enable(c0[3]), .alu_bus_sel(c0[2]),
        .mem_addr_sel(c0[1]), .we_a(c0[0]), .state(st0), .retired(ret0)
    );

    cpu_control_fsm #(.MEM_LAT(2)) u1 (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .flags(flags),
        .pc_enable(c1[9]), .pc_load(c1[8]), .pc_src(c1[7]), .ir_enable(c1[6]),
        .r_enable(c1[5]), .link_sel(c1[4]), .flags_enable(c1[3]), .alu_bus_sel(c1[2]),
        .mem_addr_sel(c1[1]), .we_a(c1[0]), .state(st1), .retired(ret1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ctl_of(int i);
        return (i == 0) ? c0 : c1;
    endfunction
    function automatic logic [2:0] st_of(int i);
        return (i == 0) ? st0 : st1;
    endfunction
    function automatic logic [15:0] ret_of(int i);
        return (i == 0) ? ret0 : ret1;
    endfunction

    // Model: position k counts cycles since the instruction started.
    bit          m_act [2];
    int          m_k   [2];
    logic [15:0] m_ret [2];

    function automatic int stage(int i);
        int lat;
        lat = i + 1;
        if (!m_act[i])          return 0;
        if (m_k[i] < lat)       return 1;
        if (m_k[i] == lat)      return 2;
        if (m_k[i] == lat + 1)  return 3;
        if (m_k[i] <= 2 * lat)  return 4;
        return 5;
    endfunction

    function automatic bit mdl_is_load(logic [15:0] ins);
        return (ins[15:12] == 4'h4) && (ins[7:4] == 4'h0);
    endfunction

    function automatic bit is_last(int i);
        return (stage(i) == 3 && !mdl_is_load(instr)) || stage(i) == 5;
    endfunction

    // Conditions come in true/negated pairs; pairs 5 and 6 list the negated form first.
    function automatic logic cond_true(logic [3:0] cc, logic [4:0] f);
        logic b;
        case (cc[3:1])
            3'd0: b = f[3];
            3'd1: b = f[0];
            3'd2: b = f[1];
            3'd3: b = f[4];
            3'd4: b = f[2];
            3'd5: b = f[1] | f[3];
            3'd6: b = f[4] | f[3];
            default: return cc[0] == 1'b0;
        endcase
        return (cc[3:1] >= 3'd5) ? (b == cc[0]) : (b != cc[0]);
    endfunction

    function automatic logic [9:0] exp_ctl(int st, logic [15:0] ins, logic [4:0] f);
        logic pe, pl, ps, ir, re, lk, fe, ab, ma, we;
        logic [3:0] op, sub;
        logic take;
        {pe, pl, ps, ir, re, lk, fe, ab, ma, we} = 10'd0;
        op   = ins[15:12];
        sub  = ins[7:4];
        take = cond_true(ins[11:8], f);
        if (st == 2) ir = 1'b1;
        else if (st == 4) ma = 1'b1;
        else if (st == 5) begin ma = 1'b1; re = 1'b1; pe = 1'b1; end
        else if (st == 3) begin
            if (op == 4'h4 && sub == 4'h0) ma = 1'b1;
            else if (op == 4'h4 && sub == 4'h4) begin ma = 1'b1; we = 1'b1; pe = 1'b1; end
            else if (op == 4'h4 && sub == 4'h8) begin re = 1'b1; lk = 1'b1; pl = 1'b1; ps = 1'b1; end
            else if (op == 4'hC || (op == 4'h4 && sub == 4'hC)) begin
                if (take) begin pl = 1'b1; ps = (op == 4'h4); end
                else pe = 1'b1;
            end else begin
                ab = 1'b1; re = 1'b1; pe = 1'b1;
                fe = !(op == 4'hD || op == 4'hF || (op == 4'h0 && sub == 4'hD));
            end
        end
        return {pe, pl, ps, ir, re, lk, fe, ab, ma, we};
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_act[i] <= 1'b0;
                m_k[i]   <= 0;
                m_ret[i] <= 16'd0;
            end else if (!m_act[i]) begin
                if (run) begin
                    m_act[i] <= 1'b1;
                    m_k[i]   <= 0;
                end
            end else if (is_last(i)) begin
                m_ret[i] <= m_ret[i] + 16'd1;
                m_k[i]   <= 0;
                if (!run) m_act[i] <= 1'b0;
            end else begin
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            chk($sformatf("cycle_u%0d", i),
                {3'b0, ctl_of(i), st_of(i), ret_of(i)},
                {3'b0, exp_ctl(stage(i), instr, flags), 3'(stage(i)), m_ret[i]});
    end

    task automatic wait_st(input int i, input logic [2:0] s, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (st_of(i) != s && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {29'b0, st_of(i)}, {29'b0, s});
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((st0 != 3'd0 || st1 != 3'd0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {26'b0, st0, st1}, 32'd0);
    endtask

    logic [15:0] r0;
    logic [17:0] seq;
    logic [15:0] mix [9] = '{16'h4340, 16'h01D2, 16'hF123, 16'hD3FF, 16'h4350,
                            16'h4E82, 16'h4304, 16'h2345, 16'hE0F0};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_u0", {3'b0, c0, st0, ret0}, 32'd0);
        chk("reset_u1", {3'b0, c1, st1, ret1}, 32'd0);
        #1 reset = 1'b1;

        // ADD back to back on MEM_LAT=1
        instr = 16'h0152; run = 1'b1;
        wait_st(0, 3'd1, "add_fetch");
        r0 = ret0;
        wait_st(0, 3'd3, "add_exec");
        chk("add_exec_ctl", {22'b0, c0}, 32'h22C);
        repeat (7) @(negedge clk);
        chk("add_retire_rate", {16'b0, ret0 - r0}, 32'd3);
        #1 run = 1'b0;
        wait_idle("add_idle");

        // LOAD on MEM_LAT=2: 1,1,2,3,4,5
        #1 instr = 16'h4304; run = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            seq = {seq[14:0], st1};
            if (j == 5) chk("load_wb_ctl", {22'b0, c1}, 32'h222);
        end
        chk("load_state_seq", {14'b0, seq}, {14'b0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
        #1 run = 1'b0;
        wait_idle("load_idle");

        // Bcond EQ taken / not taken, then code F never taken
        #1 instr = 16'hC005; flags = 5'b01000; run = 1'b1;
        wait_st(0, 3'd3, "beq_exec");
        chk("beq_taken", {22'b0, c0}, 32'h100);
        #1 flags = 5'b00000;
        #1 chk("beq_not_taken", {22'b0, c0}, 32'h200);
        #1 instr = 16'hCF05;
        for (int f = 0; f < 32; f++) begin
            flags = 5'(f);
            wait_st(0, 3'd3, "bnever_exec");
            chk("bnever_ctl", {22'b0, c0}, 32'h200);
            #1;
        end

        // All condition codes x all flag patterns, Bcond and Jcond
        for (int k = 0; k < 2; k++)
            for (int cc = 0; cc < 16; cc++)
                for (int f = 0; f < 32; f++) begin
                    instr = (k == 0) ? {4'hC, 4'(cc), 8'h05} : {4'h4, 4'(cc), 4'hC, 4'h3};
                    flags = 5'(f);
                    repeat (3) @(negedge clk);
                    #1;
                end

        // JAL and MOVI
        instr = 16'h4E82;
        wait_st(0, 3'd3, "jal_exec");
        chk("jal_ctl", {22'b0, c0}, 32'h1B0);
        #1 instr = 16'hD3FF;
        wait_st(0, 3'd3, "movi_exec");
        chk("movi_ctl", {22'b0, c0}, 32'h224);

        // Class mix with changing flags
        for (int j = 0; j < 9; j++) begin
            #1 instr = mix[j]; flags = 5'($urandom_range(0, 31));
            repeat (12) @(negedge clk);
        end
        #1 run = 1'b0;
        wait_idle("mix_idle");

        // run dropped in LATCH: instruction completes, then IDLE
        #1 instr = 16'h0152; run = 1'b1;
        wait_st(0, 3'd2, "drop_latch");
        #1 run = 1'b0;
        @(negedge clk);
        chk("drop_exec", {29'b0, st0}, 32'd3);
        @(negedge clk);
        chk("drop_idle", {19'b0, st0, c0}, 32'd0);
        wait_idle("drop_idle_both");

        // Reset during STOR execute
        #1 instr = 16'h4340; run = 1'b1;
        wait_st(0, 3'd3, "stor_exec");
        chk("stor_ctl", {22'b0, c0}, 32'h203);
        #1 reset = 1'b0;
        #1 chk("stor_abort_u0", {3'b0, c0, st0, ret0}, 32'd0);
        chk("stor_abort_u1", {3'b0, c1, st1, ret1}, 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_reset_fetch", {29'b0, st0}, 32'd1);

        // Long run of ALU instructions
        #1 instr = 16'h0152;
        repeat (6000) @(negedge clk);
        #1 run = 1'b0;
        wait_idle("long_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
